// File: rtl/mux_uart_rx_pkg.sv
// Shared definitions for the MUX 0 receive port.
// Status register bit positions, register offsets from the base address
// and the receiver FSM state type.
package mux_uart_rx_pkg;

    // Status register bit positions
    localparam int unsigned StatRdaBit = 0;
    localparam int unsigned StatTxrBit = 1;
    localparam int unsigned StatOvBit  = 2;
    localparam int unsigned StatFeBit  = 3;

    // Register offsets from BASE_ADDR
    localparam int unsigned RegStatusOff = 0;
    localparam int unsigned RegDataOff   = 1;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } rx_state_e;

endpackage

// File: rtl/mux_uart_rx_core.sv
// Serial 8N1 deserialiser for the MUX 0 receive port.
// Ports:
//   clock      system clock, rising edge
//   reset      asynchronous active-high reset
//   rx_i       raw serial line, idle high, asynchronous to clock
//   byte_o     assembled data byte (valid while done_o is high)
//   stop_ok_o  sampled stop bit level (valid while done_o is high)
//   done_o     one-clock pulse on the clock edge that samples the stop bit
module uart_rx_core
    import mux_uart_rx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx_i,
    output logic [7:0] byte_o,
    output logic       stop_ok_o,
    output logic       done_o
);

    localparam int unsigned      TickW    = $clog2(CLKS_PER_BIT);
    localparam logic [TickW-1:0] TickHalf = TickW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TickW-1:0] TickLast = TickW'(CLKS_PER_BIT - 1);

    logic [1:0]       sync_q;
    logic             rxs;
    logic             rxs_prev_q;
    logic             fall;
    rx_state_e        state_q, state_d;
    logic [TickW-1:0] tick_q;
    logic [2:0]       bit_cnt_q;
    logic [7:0]       shift_q;

    logic tick_clr;
    logic bit_clr;
    logic data_sample;

    // Two-flop synchroniser; flops reset to the idle line level so that a
    // reset never looks like a start edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q     <= 2'b11;
            rxs_prev_q <= 1'b1;
        end else begin
            sync_q     <= {sync_q[0], rx_i};
            rxs_prev_q <= sync_q[1];
        end
    end

    assign rxs = sync_q[1];
    // Requiring a high-to-low transition means a line held low after a
    // framing error cannot re-arm the receiver until it returns high.
    assign fall = rxs_prev_q & ~rxs;

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (fall) state_d = StStart;
            end
            StStart: begin
                // Mid start bit: still low means a real start, high is a glitch
                if (tick_q == TickHalf) state_d = rxs ? StIdle : StData;
            end
            StData: begin
                if (tick_q == TickLast && bit_cnt_q == 3'd7) state_d = StStop;
            end
            StStop: begin
                if (tick_q == TickLast) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Output / datapath control
    always_comb begin
        tick_clr    = 1'b0;
        bit_clr     = 1'b0;
        data_sample = 1'b0;
        done_o      = 1'b0;
        unique case (state_q)
            StIdle: begin
                tick_clr = 1'b1;
                bit_clr  = 1'b1;
            end
            StStart: begin
                tick_clr = (tick_q == TickHalf);
            end
            StData: begin
                tick_clr    = (tick_q == TickLast);
                data_sample = (tick_q == TickLast);
            end
            StStop: begin
                tick_clr = (tick_q == TickLast);
                done_o   = (tick_q == TickLast);
            end
            default: begin
                tick_clr = 1'b1;
                bit_clr  = 1'b1;
            end
        endcase
    end

    // Bit timing, bit count and LSB-first shift register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tick_q    <= '0;
            bit_cnt_q <= 3'd0;
            shift_q   <= 8'h00;
        end else begin
            tick_q <= tick_clr ? '0 : tick_q + TickW'(1);
            if (bit_clr) begin
                bit_cnt_q <= 3'd0;
            end else if (data_sample) begin
                bit_cnt_q <= bit_cnt_q + 3'd1;
            end
            if (data_sample) begin
                shift_q <= {rxs, shift_q[7:1]};
            end
        end
    end

    assign byte_o    = shift_q;
    assign stop_ok_o = rxs;

endmodule

// File: rtl/mux_uart_rx.sv
// Memory-mapped receive side of the MUX 0 serial port.
// Status at BASE_ADDR: {4'b0, fe, ov, 1'b1 (tx ready), rda}; data at BASE_ADDR+1.
// Ports:
//   clock     system clock, rising edge
//   reset     asynchronous active-high reset
//   address   CPU address bus
//   read_en   one-clock pulse marking a completed CPU read at address
//   write_en  CPU write strobe (writes are ignored)
//   rx        serial line, idle high
//   data_out  combinational read data selected by address
//   irq       high while a received byte is waiting (rda)
module mux_uart_rx
    import mux_uart_rx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter logic [15:0] BASE_ADDR    = 16'hF200
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] address,
    input  logic        read_en,
    input  logic        write_en,
    input  logic        rx,
    output logic [7:0]  data_out,
    output logic        irq
);

    localparam logic [15:0] StatusAddr = BASE_ADDR + 16'(RegStatusOff);
    localparam logic [15:0] DataAddr   = BASE_ADDR + 16'(RegDataOff);

    logic [7:0] core_byte;
    logic       core_stop_ok;
    logic       core_done;

    logic       rda_q, rda_d;
    logic       ov_q, ov_d;
    logic       fe_q, fe_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       data_read;
    logic [7:0] status;

    // Both registers are read-only
    logic unused_write_en;
    assign unused_write_en = write_en;

    uart_rx_core #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_core (
        .clock    (clock),
        .reset    (reset),
        .rx_i     (rx),
        .byte_o   (core_byte),
        .stop_ok_o(core_stop_ok),
        .done_o   (core_done)
    );

    assign data_read = read_en && (address == DataAddr);

    // A completing frame beats a simultaneous data read: the byte being
    // read is replaced, so the flags describe only the new frame.
    always_comb begin
        rda_d     = rda_q;
        ov_d      = ov_q;
        fe_d      = fe_q;
        rx_data_d = rx_data_q;
        if (core_done && (!rda_q || data_read)) begin
            rx_data_d = core_byte;
            rda_d     = 1'b1;
            ov_d      = 1'b0;
            fe_d      = ~core_stop_ok;
        end else if (core_done) begin
            // Overrun keeps the unread byte and its framing status
            ov_d = 1'b1;
        end else if (data_read) begin
            rda_d = 1'b0;
            ov_d  = 1'b0;
            fe_d  = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rda_q     <= 1'b0;
            ov_q      <= 1'b0;
            fe_q      <= 1'b0;
            rx_data_q <= 8'h00;
        end else begin
            rda_q     <= rda_d;
            ov_q      <= ov_d;
            fe_q      <= fe_d;
            rx_data_q <= rx_data_d;
        end
    end

    always_comb begin
        status             = 8'h00;
        status[StatRdaBit] = rda_q;
        status[StatTxrBit] = 1'b1;
        status[StatOvBit]  = ov_q;
        status[StatFeBit]  = fe_q;
    end

    always_comb begin
        if (address == StatusAddr) begin
            data_out = status;
        end else if (address == DataAddr) begin
            data_out = rx_data_q;
        end else begin
            data_out = 8'h00;
        end
    end

    assign irq = rda_q;

endmodule

// File: tb/tb_mux_uart_rx.sv
// Self-checking bench for mux_uart_rx: directed scenarios followed by random
// frames, compared against a register-level model of the port.
module tb_mux_uart_rx;

    localparam int unsigned Cpb        = 16;
    localparam logic [15:0] StatusAddr = 16'hF200;
    localparam logic [15:0] DataAddr   = 16'hF201;
    localparam logic [15:0] OtherAddr  = 16'h1234;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] address = StatusAddr;
    logic        read_en = 1'b0;
    logic        write_en = 1'b0;
    logic        rx = 1'b1;
    logic [7:0]  data_out;
    logic        irq;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int rise_cyc = -1;
    logic irq_prev = 1'b0;
    int fall_c;
    int lat;
    int lat_use;

    // Reference model state
    bit         m_rda, m_ov, m_fe;
    logic [7:0] m_data;

    mux_uart_rx #(
        .CLKS_PER_BIT(Cpb),
        .BASE_ADDR   (StatusAddr)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .address (address),
        .read_en (read_en),
        .write_en(write_en),
        .rx      (rx),
        .data_out(data_out),
        .irq     (irq)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (irq && !irq_prev) rise_cyc <= cyc;
        irq_prev <= irq;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] m_status();
        return {4'b0000, m_fe, m_ov, 1'b1, m_rda};
    endfunction

    task automatic model_frame(input logic [7:0] b, input bit stop);
        if (!m_rda) begin
            m_data = b;
            m_rda  = 1'b1;
            m_fe   = !stop;
        end else begin
            m_ov = 1'b1;
        end
    endtask

    task automatic model_collide(input logic [7:0] b, input bit stop);
        m_data = b;
        m_rda  = 1'b1;
        m_ov   = 1'b0;
        m_fe   = !stop;
    endtask

    task automatic model_clear();
        m_rda = 1'b0;
        m_ov  = 1'b0;
        m_fe  = 1'b0;
    endtask

    task automatic check_regs(input string tag);
        address = StatusAddr;
        #1;
        check8({tag, "/status"}, data_out, m_status());
        check8({tag, "/irq"}, {7'b0, irq}, {7'b0, m_rda});
        address = DataAddr;
        #1;
        check8({tag, "/data"}, data_out, m_data);
        address = OtherAddr;
        #1;
        check8({tag, "/other"}, data_out, 8'h00);
    endtask

    task automatic read_data();
        address = DataAddr;
        read_en = 1'b1;
        step(1);
        read_en = 1'b0;
        address = OtherAddr;
        model_clear();
    endtask

    // One 8N1 frame; optional reset pulse in the middle of data bit rst_bit
    // and an optional extra low period after the stop bit.
    task automatic send_frame(input logic [7:0] b, input bit stop, input int rst_bit,
                              input int low_tail);
        rx = 1'b0;
        step(Cpb);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            if (i == rst_bit) begin
                step(Cpb / 2);
                reset = 1'b1;
                step(2);
                reset = 1'b0;
                step(Cpb / 2 - 2);
            end else begin
                step(Cpb);
            end
        end
        rx = stop;
        step(Cpb);
        if (low_tail > 0) begin
            rx = 1'b0;
            step(low_tail);
        end
        rx = 1'b1;
        step(4);
    endtask

    initial begin
        logic [7:0] rb;
        bit         rs;

        m_rda  = 1'b0;
        m_ov   = 1'b0;
        m_fe   = 1'b0;
        m_data = 8'h00;

        reset = 1'b1;
        step(3);
        reset = 1'b0;
        step(2);
        check_regs("reset");

        // First byte with latency measurement
        fall_c = cyc;
        send_frame(8'h48, 1'b1, -1, 0);
        lat = rise_cyc - fall_c;
        vectors++;
        assert (lat >= 153 && lat <= 155) else begin
            miscompares++;
            $error("FAIL latency: observed %0d expected 153..155", lat);
        end
        model_frame(8'h48, 1'b1);
        check_regs("rx48");

        // Status read with read_en has no side effect
        address = StatusAddr;
        read_en = 1'b1;
        step(1);
        read_en = 1'b0;
        check_regs("status_read");

        read_data();
        check_regs("clear48");

        // Overrun keeps the first byte
        send_frame(8'h65, 1'b1, -1, 0);
        model_frame(8'h65, 1'b1);
        send_frame(8'h6C, 1'b1, -1, 0);
        model_frame(8'h6C, 1'b1);
        check_regs("overrun");
        read_data();
        check_regs("clear_ov");

        // Short low glitch is rejected
        rx = 1'b0;
        step(4);
        rx = 1'b1;
        step(40);
        check_regs("glitch");
        send_frame(8'h0D, 1'b1, -1, 0);
        model_frame(8'h0D, 1'b1);
        check_regs("rx0d");
        read_data();

        // Framing error, then line held low must not start a frame
        send_frame(8'hA5, 1'b0, -1, 40);
        model_frame(8'hA5, 1'b0);
        step(200);
        check_regs("fe_hold");
        read_data();
        check_regs("clear_fe");

        // Reset in the middle of a frame
        send_frame(8'hFF, 1'b1, 3, 0);
        model_clear();
        m_data = 8'h00;
        check_regs("mid_reset");
        send_frame(8'h31, 1'b1, -1, 0);
        model_frame(8'h31, 1'b1);
        check_regs("rx31");

        // Pending byte with fe and ov set, then completion on the read edge
        read_data();
        send_frame(8'h5A, 1'b0, -1, 0);
        model_frame(8'h5A, 1'b0);
        send_frame(8'h77, 1'b1, -1, 0);
        model_frame(8'h77, 1'b1);
        check_regs("ov_fe");
        lat_use = (lat >= 1 && lat <= 200) ? lat : 155;
        fork
            send_frame(8'hC3, 1'b1, -1, 0);
            begin
                step(lat_use - 1);
                address = DataAddr;
                read_en = 1'b1;
                step(1);
                read_en = 1'b0;
                address = OtherAddr;
            end
        join
        model_collide(8'hC3, 1'b1);
        check_regs("collide");
        read_data();
        check_regs("clear_collide");

        // Random frames, random stop bits, random reads and ignored writes
        for (int n = 0; n < 12; n++) begin
            rb = 8'($urandom);
            rs = ($urandom_range(0, 3) != 0);
            step($urandom_range(0, 20));
            send_frame(rb, rs, -1, 0);
            model_frame(rb, rs);
            if ($urandom_range(0, 1) == 1) begin
                address  = DataAddr;
                write_en = 1'b1;
                step(1);
                write_en = 1'b0;
            end
            check_regs("rand");
            if ($urandom_range(0, 2) != 0) begin
                read_data();
                check_regs("rand_clear");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
